inst_cache: RTL
===============

INST_CACHE -- requirements
Module: inst_cache

Interface
- REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of two, at least 2).
- REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, at least 2).
- REQ-003 SHALL use one clock and an asynchronous active-high reset, named as below.
- REQ-004 Ports:
  - clk  in  1  clock.
  - rst  in  1  asynchronous reset, active-high.
  - mem_start  in  1  fetch request strobe, sampled with mem_ready.
  - mem_ready  out  1  cache can accept a request this cycle.
  - mem_addr  in  32  byte address of the requested instruction.
  - mem_data  out  32  instruction word.
  - mem_data_valid  out  1  mem_data valid, one-cycle pulse.
  - flush  in  1  invalidate all lines (fence.i).
  - bus_start  out  1  backing-memory word read request.
  - bus_ready  in  1  backing memory can accept a request.
  - bus_addr  out  32  word-aligned backing-memory address.
  - bus_rdata  in  32  backing-memory read data.
  - bus_rvalid  in  1  bus_rdata valid.

Function
- REQ-005 Request accept: the cache SHALL accept a request when mem_start && mem_ready at a rising edge, latching mem_addr; mem_addr[1:0] is ignored.
- REQ-006 Address split: offset = addr[2+:log2(LINE_WORDS)], index = next log2(LINES) bits, tag = the remaining upper bits.
- REQ-007 States: IDLE, RESP, REFILL_REQ, REFILL_WAIT.
- REQ-008 IDLE: mem_ready=1. On accept, go to RESP.
- REQ-009 RESP, hit (valid[index] and tag equal):
  - drive mem_data_valid=1 and mem_data=word for exactly this cycle; hit latency is 1 cycle after accept;
  - mem_ready=1; a same-cycle accept stays in RESP, otherwise go to IDLE.
- REQ-010 RESP, miss: mem_data_valid=0, mem_ready=0, go to REFILL_REQ with word counter=0.
- REQ-011 REFILL_REQ: bus_start=bus_ready; bus_addr={tag,index,counter,2'b00}; on bus_ready go to REFILL_WAIT.
- REQ-012 REFILL_WAIT: on bus_rvalid, write bus_rdata into line word[counter] and increment the counter.
  - Counter wraps at LINE_WORDS: write the tag, set valid, go to RESP; the replay then hits.
  - Otherwise return to REFILL_REQ.
- REQ-013 Refill words SHALL be fetched in order 0..LINE_WORDS-1; at most one bus request is outstanding.
- REQ-014 mem_start while mem_ready=0 SHALL be ignored.
- REQ-015 flush in IDLE or RESP: clear all valid bits at the edge; a RESP hit in the same cycle is still delivered.
- REQ-016 flush during REFILL_*: complete the refill and deliver the replay response, but leave that line invalid. A pending-flush flag SHALL clear all valid bits when the refill ends.
- REQ-017 bus_rvalid outside REFILL_WAIT SHALL be ignored.

Reset
- REQ-018 On rst: state=IDLE, all valid bits=0, counter=0, mem_data_valid=0, bus_start=0, mem_ready=1 after release; data and tag arrays are not reset.
- REQ-019 Reset mid-refill SHALL abandon the line (it stays invalid), and a late bus_rvalid SHALL be ignored per REQ-017.

Configuration
- REQ-020 Macro INST_CACHE_STATS_EN SHALL control two extra 32-bit outputs, stat_hits and stat_misses.
  - stat_hits counts each RESP hit that is not a replay after a refill.
  - stat_misses counts each RESP miss.
  - Both counters wrap and are cleared by rst.
- REQ-021 Without INST_CACHE_STATS_EN the ports and counters SHALL be absent; behaviour is otherwise identical.

Structure
- REQ-022 Package core_pkg SHALL hold the state enum, INST_NOP and the address-field width localparams derived from LINES/LINE_WORDS.
- REQ-023 Tag, valid and data storage SHALL be the sub-module inst_cache_array: asynchronous read, synchronous single-word write, with tag write and whole-array valid clear.

Verification
- REQ-024 Cold miss: start with addr 0x100 -> 4 bus reads at 0x100, 0x104, 0x108, 0x10C; then mem_data_valid with the word at 0x100; stat_misses=1.
- REQ-025 Streaming hits: after REQ-024, back-to-back starts at 0x104, 0x108, 0x10C -> valid on consecutive cycles with no bus traffic; stat_hits=3.
- REQ-026 Conflict: LINES=16, access 0x000 then 0x100 -> second access refills index 0 and evicts; re-access 0x000 misses again.
- REQ-027 Flush mid-refill: flush asserted in the second REFILL_WAIT -> response delivered, then re-access of the same address misses.
- REQ-028 Bus stall: bus_ready held low for 10 cycles -> bus_start=0 and mem_ready=0 throughout; the refill resumes when bus_ready rises.
- REQ-029 Reset mid-refill: rst after 2 of 4 words, stray bus_rvalid afterwards -> IDLE, mem_ready=1, and the next access to that line misses.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and address-field helpers for the instruction cache.
// Field widths come from functions so any legal LINES/LINE_WORDS pair can use them.
package core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_REFILL_REQ,
        ST_REFILL_WAIT
    } ic_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int line_words);
        return 30 - $clog2(lines) - $clog2(line_words);
    endfunction

    localparam int DEF_OFF_W = off_w(DEF_LINE_WORDS);
    localparam int DEF_IDX_W = idx_w(DEF_LINES);
    localparam int DEF_TAG_W = tag_w(DEF_LINES, DEF_LINE_WORDS);

endpackage

// File: rtl/inst_cache_array.sv
// Tag/valid/data storage: asynchronous read, one data word written per cycle,
// tag write sets the line valid, and a single strobe clears every valid bit.
module inst_cache_array
    import core_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [idx_w(LINES)-1:0]               rd_idx,
    input  logic [off_w(LINE_WORDS)-1:0]          rd_off,
    output logic                                  rd_valid,
    output logic [tag_w(LINES, LINE_WORDS)-1:0]   rd_tag,
    output logic [31:0]                           rd_word,
    input  logic                                  wr_en,
    input  logic [idx_w(LINES)-1:0]               wr_idx,
    input  logic [off_w(LINE_WORDS)-1:0]          wr_off,
    input  logic [31:0]                           wr_word,
    input  logic                                  tag_we,
    input  logic [tag_w(LINES, LINE_WORDS)-1:0]   tag_wdata,
    input  logic                                  clr_all
);
    localparam int TAG_W = tag_w(LINES, LINE_WORDS);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][LINE_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_word  = data_mem[rd_idx][rd_off];

    // Clear wins over set so a flush landing on the last refill beat leaves the line invalid.
    always_comb begin
        valid_d = valid_q;
        if (clr_all)
            valid_d = '0;
        else if (tag_we)
            valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            data_mem[wr_idx][wr_off] <= wr_word;
        if (tag_we)
            tag_mem[wr_idx] <= tag_wdata;
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache; misses refill the whole line word by word, then replay.
// Defining INST_CACHE_STATS_EN adds the stat_hits / stat_misses counter outputs.
module inst_cache
    import core_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_start,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_data_valid,
    input  logic        flush,
    output logic        bus_start,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid
`ifdef INST_CACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, LINE_WORDS);

    ic_state_e        state_q, state_d;
    logic [31:2]      addr_q, addr_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             replay_q, replay_d;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_word;
    logic             hit;
    logic             wr_en, tag_we, clr_all;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[1:0];
    assign off      = addr_q[2 +: OFF_W];
    assign idx      = addr_q[2+OFF_W +: IDX_W];
    assign tag      = addr_q[31 -: TAG_W];
    assign bus_addr = {addr_q[31:2+OFF_W], cnt_q, 2'b00};
    // The replay right after a refill is served even if a flush already invalidated the line.
    assign hit      = replay_q || (rd_valid && (rd_tag == tag));

    inst_cache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx),
        .rd_off    (off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .wr_en     (wr_en),
        .wr_idx    (idx),
        .wr_off    (cnt_q),
        .wr_word   (bus_rdata),
        .tag_we    (tag_we),
        .tag_wdata (tag),
        .clr_all   (clr_all)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        flush_pend_d   = flush_pend_q;
        replay_d       = 1'b0;
        mem_ready      = 1'b0;
        mem_data_valid = 1'b0;
        mem_data       = INST_NOP;
        bus_start      = 1'b0;
        wr_en          = 1'b0;
        tag_we         = 1'b0;
        clr_all        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_ready = 1'b1;
                clr_all   = flush;
                if (mem_start) begin
                    addr_d  = mem_addr[31:2];
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                clr_all = flush;
                if (hit) begin
                    mem_ready      = 1'b1;
                    mem_data_valid = 1'b1;
                    mem_data       = rd_word;
                    if (mem_start) begin
                        addr_d  = mem_addr[31:2];
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                    state_d      = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ: begin
                bus_start = bus_ready;
                if (flush)
                    flush_pend_d = 1'b1;
                if (bus_ready)
                    state_d = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                if (flush)
                    flush_pend_d = 1'b1;
                if (bus_rvalid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        clr_all      = flush_pend_q || flush;
                        tag_we       = !(flush_pend_q || flush);
                        flush_pend_d = 1'b0;
                        replay_d     = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        state_d = ST_REFILL_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            replay_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            replay_q     <= replay_d;
        end
    end

`ifdef INST_CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (state_q == ST_RESP) begin
            if (hit && !replay_q)
                stat_hits_d = stat_hits_q + 32'd1;
            else if (!hit)
                stat_misses_d = stat_misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule
